// File: rtl/gauss_pkg.sv
// Shared definitions for the Gaussian sampler's uniform source:
// taus88 constants, state/step types, the step/seed functions and FSM states.
package gauss_pkg;

    // Seed-scrambling constants, one per Tausworthe component
    localparam logic [31:0] TAUS_C1 = 32'h1F123BB5;
    localparam logic [31:0] TAUS_C2 = 32'h159A55E5;
    localparam logic [31:0] TAUS_C3 = 32'h075BCD15;

    // taus88 needs s1>1, s2>7, s3>15; forcing one bit on guarantees it
    localparam logic [31:0] TAUS_MIN1 = 32'h0000_0002;
    localparam logic [31:0] TAUS_MIN2 = 32'h0000_0008;
    localparam logic [31:0] TAUS_MIN3 = 32'h0000_0010;

    typedef struct packed {
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] s3;
    } taus_state_t;

    typedef struct packed {
        taus_state_t state;
        logic [31:0] draw;
    } taus_step_t;

    // Enumerators carry a prefix so they never collide with the WARMUP parameter
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } fsm_e;

    // Expand a 32-bit seed into the three component states
    function automatic taus_state_t taus_seed(input logic [31:0] sd);
        taus_state_t s;
        s.s1 = (sd ^ TAUS_C1) | TAUS_MIN1;
        s.s2 = ({sd[15:0], sd[31:16]} ^ TAUS_C2) | TAUS_MIN2;
        s.s3 = (~sd ^ TAUS_C3) | TAUS_MIN3;
        return s;
    endfunction

    // One taus88 step: next component states and the combined 32-bit draw
    function automatic taus_step_t taus_step(input taus_state_t s);
        taus_step_t r;
        r.state.s1 = ((s.s1 & ~32'h1) << 12) ^ (((s.s1 << 13) ^ s.s1) >> 19);
        r.state.s2 = ((s.s2 & ~32'h7) << 4)  ^ (((s.s2 << 2)  ^ s.s2) >> 25);
        r.state.s3 = ((s.s3 & ~32'hF) << 17) ^ (((s.s3 << 3)  ^ s.s3) >> 11);
        r.draw     = r.state.s1 ^ r.state.s2 ^ r.state.s3;
        return r;
    endfunction

endpackage

// File: rtl/taus88_core.sv
// taus88 URNG: holds the three component states, loads them from a seed,
// advances them on request. o_draw is the value the next step produces,
// so the consumer registers it on the same edge the state advances.
module taus88_core
    import gauss_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,        // asynchronous, active-high
    input  logic        i_seed_load,  // wins over i_step
    input  logic        i_step,
    input  logic [31:0] i_sd,
    output logic [31:0] o_draw
);

    taus_state_t r_state;
    taus_step_t  w_next;

    // Next state and draw from the current state
    always_comb begin
        w_next = taus_step(r_state);
    end

    assign o_draw = w_next.draw;

    // Component state registers: seed load has priority over stepping
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= '0;
        end else if (i_seed_load) begin
            r_state <= taus_seed(i_sd);
        end else if (i_step) begin
            r_state <= w_next.state;
        end
    end

endmodule

// File: rtl/uniform_pair_source.sv
// Uniform (u1,u2) pair source for the Box-Muller core. Pairs consecutive
// taus88 draws (even -> u1, odd -> u2), buffers them in a small FIFO and
// offers the head on a valid/ready port.
// Handshake: a pair transfers on every rising edge where u_valid_o and
// u_ready_i are both 1; u_valid_o depends only on registered state and never
// on u_ready_i. A seed load on the same edge flushes the buffer instead.
// Note: rstn is an active-high asynchronous reset despite its name.
module uniform_pair_source
    import gauss_pkg::*;
#(
    parameter int OUT_W      = 32,  // 1..32
    parameter int WARMUP     = 16,  // 0..255
    parameter int FIFO_DEPTH = 2    // 2..8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [31:0]      sd_i,
    input  logic             seed_load_i,
    input  logic             en_i,
    output logic             u_valid_o,
    input  logic             u_ready_i,
    output logic [OUT_W-1:0] u1_o,
    output logic [OUT_W-1:0] u2_o,
    output logic             busy_o,
    output fsm_e             dbg_state_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]       WARM_LAST = 8'((WARMUP > 0) ? (WARMUP - 1) : 0);

    fsm_e             r_state;
    logic [7:0]       r_warm_cnt;
    logic             r_half;
    logic [OUT_W-1:0] r_u1_hold;
    logic [2*OUT_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_step;
    logic             w_valid;
    logic             w_pop;
    logic             w_pop_eff;
    logic             w_run_step;
    logic             w_push;
    logic [31:0]      w_draw;
    logic [OUT_W-1:0] w_trunc;
    logic [OUT_W-1:0] w_u1;

    taus88_core u_core (
        .i_clk       (clk),
        .i_rst       (rstn),
        .i_seed_load (seed_load_i),
        .i_step      (w_step),
        .i_sd        (sd_i),
        .o_draw      (w_draw)
    );

    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid & u_ready_i;
    assign w_pop_eff  = w_pop & ~seed_load_i;
    assign w_run_step = (r_state == ST_RUN) & w_step & ~seed_load_i;
    assign w_push     = w_run_step & r_half;

    // u1 feeds ln(), so an all-zero truncation is bumped to one LSB
    assign w_trunc = w_draw[31 -: OUT_W];
    assign w_u1    = (w_trunc == '0) ? OUT_W'(1) : w_trunc;

    // Step request: always during warm-up; in RUN only when a pair slot is or becomes free
    always_comb begin
        w_step = 1'b0;
        case (r_state)
            ST_WARMUP: w_step = 1'b1;
            ST_RUN:    w_step = en_i & ((r_count < DEPTH_C) | w_pop);
            default:   w_step = 1'b0;
        endcase
    end

    // Control FSM: seed load restarts warm-up from any state
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_state    <= ST_IDLE;
            r_warm_cnt <= '0;
        end else if (seed_load_i) begin
            r_warm_cnt <= '0;
            r_state    <= (WARMUP == 0) ? ST_RUN : ST_WARMUP;
        end else begin
            case (r_state)
                ST_WARMUP: begin
                    r_warm_cnt <= r_warm_cnt + 8'd1;
                    if (r_warm_cnt == WARM_LAST) begin
                        r_state <= ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pairing: even draw parks in the u1 holding register, odd draw completes the pair
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_half    <= 1'b0;
            r_u1_hold <= '0;
        end else if (seed_load_i) begin
            r_half <= 1'b0;
        end else if (w_run_step) begin
            if (!r_half) begin
                r_u1_hold <= w_u1;
            end
            r_half <= ~r_half;
        end
    end

    // Pair FIFO: circular buffer with occupancy count; push and pop may coincide when full
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (seed_load_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {r_u1_hold, w_trunc};
                r_wr_ptr        <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_eff) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop_eff})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign u_valid_o        = w_valid;
    assign {u1_o, u2_o}     = r_mem[r_rd_ptr];
    assign busy_o           = (r_state == ST_WARMUP);
    assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_uniform_pair_source.sv
// Bench for uniform_pair_source: two instances (full width with warm-up,
// 4-bit width without warm-up) share stimulus; a reference draw sequence
// built from the seed rules feeds per-instance expected-pair queues that a
// negedge monitor pops on every handshake.
module tb_uniform_pair_source;
    import gauss_pkg::*;

    localparam int A_W = 32, A_WARM = 16, A_DEPTH = 2;
    localparam int B_W = 4,  B_WARM = 0,  B_DEPTH = 3;
    localparam int N_EXP = 1400;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [31:0] sd_i = '0;
    logic        seed_load_i = 1'b0;
    logic        en_i = 1'b1;
    logic        u_ready_i = 1'b1;

    logic           a_valid, a_busy;
    logic [A_W-1:0] a_u1, a_u2;
    fsm_e           a_state;
    logic           b_valid, b_busy;
    logic [B_W-1:0] b_u1, b_u2;
    fsm_e           b_state;

    int errors = 0;
    int checks = 0;
    int a_pairs = 0;
    int b_pairs = 0;

    logic [2*A_W-1:0] exp_a_q[$];
    logic [2*B_W-1:0] exp_b_q[$];

    uniform_pair_source #(.OUT_W(A_W), .WARMUP(A_WARM), .FIFO_DEPTH(A_DEPTH)) u_dut_a (
        .clk(clk), .rstn(rstn), .sd_i(sd_i), .seed_load_i(seed_load_i), .en_i(en_i),
        .u_valid_o(a_valid), .u_ready_i(u_ready_i), .u1_o(a_u1), .u2_o(a_u2),
        .busy_o(a_busy), .dbg_state_o(a_state)
    );

    uniform_pair_source #(.OUT_W(B_W), .WARMUP(B_WARM), .FIFO_DEPTH(B_DEPTH)) u_dut_b (
        .clk(clk), .rstn(rstn), .sd_i(sd_i), .seed_load_i(seed_load_i), .en_i(en_i),
        .u_valid_o(b_valid), .u_ready_i(u_ready_i), .u1_o(b_u1), .u2_o(b_u2),
        .busy_o(b_busy), .dbg_state_o(b_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Draw sequence after a seed load, straight from the taus88 recurrences
    task automatic build_expected(input logic [31:0] sd);
        logic [31:0] s1, s2, s3, b;
        logic [31:0] draws[$];
        logic [31:0] x1, x2;
        logic [A_W-1:0] a1, a2;
        logic [B_W-1:0] c1, c2;
        s1 = (sd ^ 32'h1F123BB5) | 32'h2;
        s2 = ({sd[15:0], sd[31:16]} ^ 32'h159A55E5) | 32'h8;
        s3 = (~sd ^ 32'h075BCD15) | 32'h10;
        for (int i = 0; i < A_WARM + 2 * N_EXP; i++) begin
            b  = ((s1 << 13) ^ s1) >> 19;
            s1 = ((s1 & ~32'h1) << 12) ^ b;
            b  = ((s2 << 2) ^ s2) >> 25;
            s2 = ((s2 & ~32'h7) << 4) ^ b;
            b  = ((s3 << 3) ^ s3) >> 11;
            s3 = ((s3 & ~32'hF) << 17) ^ b;
            draws.push_back(s1 ^ s2 ^ s3);
        end
        exp_a_q.delete();
        exp_b_q.delete();
        for (int p = 0; p < N_EXP; p++) begin
            // full width: warm-up draws skipped
            x1 = draws[A_WARM + 2 * p];
            x2 = draws[A_WARM + 2 * p + 1];
            a1 = (x1 == 32'd0) ? 32'd1 : x1;
            a2 = x2;
            exp_a_q.push_back({a1, a2});
            // 4-bit: no warm-up, top nibble, zero u1 replaced by 1
            x1 = draws[B_WARM + 2 * p] >> 28;
            x2 = draws[B_WARM + 2 * p + 1] >> 28;
            c1 = (x1 == 32'd0) ? 4'd1 : x1[3:0];
            c2 = x2[3:0];
            exp_b_q.push_back({c1, c2});
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rstn && !seed_load_i && u_ready_i) begin
            if (a_valid) begin
                if (exp_a_q.size() == 0) begin
                    check("a_unexpected_pair", 64'(1), 64'(0));
                end else begin
                    check("a_pair", 64'({a_u1, a_u2}), 64'(exp_a_q.pop_front()));
                    a_pairs++;
                end
            end
            if (b_valid) begin
                check("b_u1_nonzero", 64'(b_u1 != '0), 64'(1));
                if (exp_b_q.size() == 0) begin
                    check("b_unexpected_pair", 64'(1), 64'(0));
                end else begin
                    check("b_pair", 64'({b_u1, b_u2}), 64'(exp_b_q.pop_front()));
                    b_pairs++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; the next rising edge samples the load
    task automatic load_seed(input logic [31:0] sd);
        sd_i = sd;
        seed_load_i = 1'b1;
        build_expected(sd);
        @(posedge clk);
        #1;
        seed_load_i = 1'b0;
    endtask

    task automatic wait_pairs(input int n_a, input int budget);
        int cyc;
        cyc = 0;
        while (a_pairs < n_a && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check("wait_pairs_timeout", 64'(a_pairs >= n_a), 64'(1));
    endtask

    task automatic stall(input int n);
        @(posedge clk);
        #1;
        u_ready_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n_run;
        int start_pairs;
        int any_valid;
        logic [31:0] rnd_sd;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_valid", 64'(a_valid), 64'(0));
        check("rst_a_u1", 64'(a_u1), 64'(0));
        check("rst_a_u2", 64'(a_u2), 64'(0));
        check("rst_a_busy", 64'(a_busy), 64'(0));
        check("rst_a_state", 64'(a_state), 64'(ST_IDLE));
        check("rst_b_valid", 64'(b_valid), 64'(0));
        check("rst_b_u1", 64'(b_u1), 64'(0));
        rstn = 1'b0;

        // idle without seed: nothing happens
        repeat (5) @(negedge clk);
        check("idle_a_valid", 64'(a_valid), 64'(0));
        check("idle_a_state", 64'(a_state), 64'(ST_IDLE));
        check("idle_b_valid", 64'(b_valid), 64'(0));

        // seed 0, latency profile: busy cycles 1..16, first valid cycle 19, then every 2
        @(posedge clk);
        #1;
        load_seed(32'd0);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            check($sformatf("lat_a_busy_c%0d", k), 64'(a_busy), 64'(k >= 1 && k <= A_WARM));
            check($sformatf("lat_a_valid_c%0d", k), 64'(a_valid),
                  64'(k >= A_WARM + 3 && ((k - A_WARM - 3) % 2) == 0));
            check($sformatf("lat_b_busy_c%0d", k), 64'(b_busy), 64'(0));
        end

        // long golden run
        wait_pairs(1000, 4000);

        // back-pressure: fill, then release with no loss
        stall(50);
        check("stall_a_valid", 64'(a_valid), 64'(1));
        check("stall_b_valid", 64'(b_valid), 64'(1));
        @(posedge clk);
        #1;
        u_ready_i = 1'b1;
        n_run = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!a_valid) break;
            n_run++;
        end
        check("release_a_burst_ge_depth", 64'(n_run >= A_DEPTH), 64'(1));
        repeat (40) @(negedge clk);

        // enable low: FIFO drains, URNG holds, then resumes in sequence
        @(posedge clk);
        #1;
        en_i = 1'b0;
        repeat (20) @(negedge clk);
        check("en0_a_drained", 64'(a_valid), 64'(0));
        check("en0_b_drained", 64'(b_valid), 64'(0));
        start_pairs = a_pairs;
        @(posedge clk);
        #1;
        en_i = 1'b1;
        repeat (40) @(negedge clk);
        check("en1_a_resumed", 64'(a_pairs > start_pairs), 64'(1));

        // seed load coincident with a pop while full
        stall(50);
        check("full_a_valid", 64'(a_valid), 64'(1));
        @(posedge clk);
        #1;
        u_ready_i = 1'b1;
        load_seed(32'd0);
        @(negedge clk);
        check("reload_a_valid", 64'(a_valid), 64'(0));
        check("reload_b_valid", 64'(b_valid), 64'(0));
        check("reload_a_busy", 64'(a_busy), 64'(1));
        start_pairs = a_pairs;
        wait_pairs(start_pairs + 60, 400);

        // asynchronous reset mid-run
        @(posedge clk);
        #3;
        rstn = 1'b1;
        exp_a_q.delete();
        exp_b_q.delete();
        #1;
        check("arst_a_valid", 64'(a_valid), 64'(0));
        check("arst_a_u1", 64'(a_u1), 64'(0));
        check("arst_a_u2", 64'(a_u2), 64'(0));
        check("arst_a_busy", 64'(a_busy), 64'(0));
        check("arst_a_state", 64'(a_state), 64'(ST_IDLE));
        check("arst_b_valid", 64'(b_valid), 64'(0));
        @(posedge clk);
        #1;
        rstn = 1'b0;
        any_valid = 0;
        repeat (30) begin
            @(negedge clk);
            if (a_valid || b_valid) any_valid++;
        end
        check("post_rst_no_pairs", 64'(any_valid), 64'(0));

        // randomized ready/enable with occasional reseeding
        @(posedge clk);
        #1;
        rnd_sd = $urandom;
        load_seed(rnd_sd);
        for (int i = 0; i < 800; i++) begin
            u_ready_i = ($urandom_range(0, 3) != 0);
            en_i      = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 299) == 0) begin
                rnd_sd = $urandom;
                load_seed(rnd_sd);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        u_ready_i = 1'b1;
        en_i = 1'b1;
        repeat (100) @(negedge clk);

        check("total_a_pairs", 64'(a_pairs >= 1100), 64'(1));
        check("total_b_pairs", 64'(b_pairs >= 1100), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
